// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the buart receive FIFO: ingress FSM encoding,
// default depth and IO-mux status bit positions.
package uart_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_GUARD = 2'd2
    } rx_state_t;

    localparam int DEFAULT_DEPTH_LOG2 = 4;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x 8 register file: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module rx_fifo_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int ENTRIES = 1 << ADDR_W;

    logic [7:0] mem_r [0:ENTRIES-1];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between buart and the J1 IO bus. Optional rts_n hysteresis
// flow control is built only when UART_RX_FIFO_RTS_EN is defined.
module uart_rx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
`ifdef UART_RX_FIFO_RTS_EN
    ,
    parameter int RTS_HI = 12,
    parameter int RTS_LO = 4
`endif
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  uart_valid,
    input  logic [7:0]            uart_data,
    output logic                  uart_rd,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  ovr_clr
`ifdef UART_RX_FIFO_RTS_EN
    ,
    output logic                  rts_n
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    rx_state_t             state_r;
    logic                  uart_rd_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  overrun_r;

    logic in_ack_s;
    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;

    assign full_s   = (count_r == COUNT_FULL);
    assign empty_s  = (count_r == COUNT_ZERO);
    assign in_ack_s = (state_r == ST_ACK);
    // A pop in the ACK cycle frees the slot the incoming byte needs.
    assign push_s   = in_ack_s && (!full_s || pop);
    assign pop_s    = pop && !empty_s;

    // Ingress handshake: IDLE -> ACK (one-cycle uart_rd) -> GUARD -> IDLE.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_r   <= ST_IDLE;
            uart_rd_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (uart_valid) begin
                        state_r   <= ST_ACK;
                        uart_rd_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        uart_rd_r <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_r   <= ST_GUARD;
                    uart_rd_r <= 1'b0;
                end
                ST_GUARD: begin
                    state_r   <= ST_IDLE;
                    uart_rd_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    uart_rd_r <= 1'b0;
                end
            endcase
        end
    end

    // Pointers and fill level; count moves only when exactly one side acts.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overrun: a discarded byte wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overrun_r <= 1'b0;
        end else if (in_ack_s && !push_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end
    end

    rx_fifo_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (uart_data),
        .raddr (rd_ptr_r),
        .rdata (head)
    );

`ifdef UART_RX_FIFO_RTS_EN
    localparam logic [DEPTH_LOG2:0] RTS_HI_C = (DEPTH_LOG2 + 1)'(RTS_HI);
    localparam logic [DEPTH_LOG2:0] RTS_LO_C = (DEPTH_LOG2 + 1)'(RTS_LO);

    logic rts_n_r;

    // Flow-control hysteresis between RTS_LO and RTS_HI.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rts_n_r <= 1'b0;
        end else if (count_r >= RTS_HI_C) begin
            rts_n_r <= 1'b1;
        end else if (count_r <= RTS_LO_C) begin
            rts_n_r <= 1'b0;
        end
    end

    assign rts_n = rts_n_r;
`endif

    assign uart_rd = uart_rd_r;
    assign count   = count_r;
    assign empty   = empty_s;
    assign full    = full_s;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus random traffic
// compared against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_rd;
    logic       pop = 1'b0;
    logic [7:0] head;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr = 1'b0;
`ifdef UART_RX_FIFO_RTS_EN
    logic       rts_n;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    bit         ovr = 1'b0;

    uart_rx_fifo dut (
        .clk        (clk),
        .resetq     (resetq),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_rd    (uart_rd),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
`ifdef UART_RX_FIFO_RTS_EN
        ,
        .rts_n      (rts_n)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},   32'(count),   32'(q.size()));
        chk({tag, ".empty"},   32'(empty),   32'(q.size() == 0));
        chk({tag, ".full"},    32'(full),    32'(q.size() == 16));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
        if (q.size() > 0) begin
            chk({tag, ".head"}, 32'(head), 32'(q[0]));
        end
    endtask

    // Offer one byte from buart, optionally popping during the acknowledge cycle.
    task automatic send(input logic [7:0] b, input bit pop_ack);
        int lat;
        bit seen;
        bit was_full;
        lat = 0;
        seen = 1'b0;
        uart_valid = 1'b1;
        uart_data = b;
        for (int i = 1; i <= 4 && !seen; i++) begin
            @(negedge clk);
            if (uart_rd) begin
                seen = 1'b1;
                lat = i;
            end
        end
        chk("send.ack_latency", 32'(lat), 32'd1);
        uart_valid = 1'b0;
        if (seen) begin
            if (pop_ack && q.size() > 0) begin
                chk("send.head_before_pop", 32'(head), 32'(q[0]));
            end
            pop = pop_ack;
            @(negedge clk);
            pop = 1'b0;
            chk("send.rd_single_pulse", 32'(uart_rd), 32'd0);
            was_full = (q.size() == 16);
            if (pop_ack && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (!was_full || pop_ack) begin
                q.push_back(b);
            end else begin
                ovr = 1'b1;
            end
            check_state("send");
            @(negedge clk);
        end
    endtask

    task automatic do_pop();
        if (q.size() > 0) begin
            chk("pop.head", 32'(head), 32'(q[0]));
        end
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
        end
        check_state("pop");
    endtask

    task automatic do_clr();
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        ovr = 1'b0;
        check_state("clr");
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check_state("reset");
        chk("reset.uart_rd", 32'(uart_rd), 32'd0);
        resetq = 1'b1;
        @(negedge clk);

        // single byte, then drain
        send(8'h41, 1'b0);
        do_pop();

        // fill completely and overflow
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h30 + i), 1'b0);
        end
        send(8'h55, 1'b0);
        do_clr();
        send(8'h77, 1'b1);
        for (int i = 0; i < 16; i++) begin
            do_pop();
        end
        do_pop();

        // random traffic against the queue model
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5) begin
                send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
            end else if (op < 9) begin
                do_pop();
            end else begin
                do_clr();
            end
        end

        // reset during the acknowledge cycle with 3 entries and overrun set
        while (q.size() > 0) do_pop();
        for (int i = 0; i < 17; i++) begin
            send(8'($urandom_range(0, 255)), 1'b0);
        end
        for (int i = 0; i < 13; i++) begin
            do_pop();
        end
        uart_valid = 1'b1;
        uart_data = 8'hA5;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = uart_rd;
        end
        chk("rst_ack.reached_ack", 32'(seen), 32'd1);
        resetq = 1'b0;
        #1;
        q.delete();
        ovr = 1'b0;
        chk("rst_ack.uart_rd", 32'(uart_rd), 32'd0);
        check_state("rst_ack");
        uart_valid = 1'b0;
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        check_state("post_reset");
        send(8'h5A, 1'b0);
        do_pop();

`ifdef UART_RX_FIFO_RTS_EN
        for (int i = 0; i < 11; i++) begin
            send(8'(i), 1'b0);
        end
        chk("rts.at11", 32'(rts_n), 32'd0);
        send(8'hC0, 1'b0);
        chk("rts.at12", 32'(rts_n), 32'd1);
        for (int i = 0; i < 7; i++) begin
            do_pop();
        end
        @(negedge clk);
        chk("rts.at5", 32'(rts_n), 32'd1);
        do_pop();
        @(negedge clk);
        chk("rts.at4", 32'(rts_n), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
